life_engine_ctrl: RTL and testbench
===================================

// Module: life_engine_ctrl
// PURPOSE
// - Parametrised Game of Life engine plus run controller for a ROWS x COLS board; successor to the fixed 16x16 machine.
// - Single clock domain. A tick counter gates generation updates; no derived clocks.
// - Next generation is computed row-serially into a shadow buffer, then committed atomically.
// - Adds: single-step, clear, selectable toroidal/dead-edge boundary, extinction flag.
// - Sits between debounced button/switch front-end and display driver.
// PARAMETERS
// - ROWS      16         board rows (>=3)
// - COLS      16         board columns (>=3)
// - RW        4          row index width, clog2(ROWS)
// - TICK_DIV  268435456  ClkPort cycles between generations in RUN (>=1)
// - GEN_W     16         generation counter width
// PORTS
// - ClkPort        in   1          system clock
// - reset          in   1          asynchronous, active-high
// - start_stop_i   in   1          1-cycle pulse: SET/PAUSE->RUN, RUN->PAUSE
// - step_i         in   1          1-cycle pulse: compute exactly one generation from SET/PAUSE
// - clear_i        in   1          1-cycle pulse: zero board and counters, go to SET
// - wrap_i         in   1          1 = toroidal edges, 0 = cells outside board are dead
// - edit_we_i      in   1          write edit_data_i into row edit_row_i
// - edit_row_i     in   RW         row to edit
// - edit_data_i    in   COLS       row contents, bit c = column c
// - board_o        out  ROWS*COLS  live board, cell (r,c) at bit r*COLS+c
// - generation_cnt_o out GEN_W     generations committed since reset/clear
// - state_o        out  2          00 SET, 01 RUN, 10 PAUSE, 11 CALC
// - busy_o         out  1          high while in CALC
// - extinct_o      out  1          high when board_o == 0
// BEHAVIOUR
// - Reset (async): board_o=0, generation_cnt_o=0, state=SET, tick counter=0, row index=0; busy_o=0, extinct_o=1.
// - Rule B3/S23: dead cell with exactly 3 live neighbours is born; live cell with 2 or 3 survives; all others die.
// - SET: edits allowed. start_stop_i -> RUN (tick counter cleared). step_i -> CALC, return state SET.
// - RUN: tick counter increments each cycle. On reaching TICK_DIV-1: clear counter, enter CALC, return state RUN.
//   start_stop_i -> PAUSE, tick counter cleared. Edits and step_i ignored.
// - PAUSE: edits allowed. start_stop_i -> RUN. step_i -> CALC, return state PAUSE.
// - CALC: wrap_i sampled on entry and held. Cycle k (k=0..ROWS-1) writes shadow row k from board rows k-1,k,k+1.
//   Cycle ROWS: commit board_o<=shadow, generation_cnt_o+1 (wraps mod 2^GEN_W), return to saved state.
//   Latency: ROWS+1 cycles from CALC entry to commit. board_o is unchanged until commit.
//   start_stop_i, step_i and edits are ignored during CALC. A start_stop_i that arrives during CALC is lost.
// - Edge handling: wrap=1 uses row/column indices mod ROWS/COLS. wrap=0 treats out-of-range cells as 0.
// - Edits: board_o row edit_row_i <= edit_data_i on the next edge. edit_row_i >= ROWS is ignored.
// - Simultaneous pulses, by priority: clear_i > start_stop_i > step_i > edit_we_i.
//   Any two in the same cycle: only the highest-priority one acts.
// - clear_i in any state, including mid-CALC: aborts the calculation, discards shadow, board_o=0, count=0, state=SET.
// - Reset asserted mid-CALC: same as clear; no partial commit is ever visible.
// - extinct_o is combinational from board_o. The engine keeps stepping an empty board; the count still increments.
// TESTING
// - Blinker: set rows 7,8,9 col 8; step_i -> after 17 cycles, row 8 cols 7..9 live, gen=1; second step restores the original.
// - Glider, wrap=1, TICK_DIV=4, run 64 generations -> glider returns to its start position, gen=64, extinct_o=0.
// - Glider, wrap=0, run until it reaches the corner -> it decays to a 2x2 block, no live cells wrap to the opposite edge.
// - clear_i on CALC cycle 5 -> board_o=0, gen=0, state_o=00 next cycle; no commit occurs.
// - Simultaneous start_stop_i and step_i in PAUSE -> state RUN, no CALC entry. edit_we_i during RUN -> board unchanged.
// - GEN_W=3, run 9 generations -> generation_cnt_o=1 (wrap). Block pattern stays stable and extinct_o=0 throughout.

Source files
------------

// File: rtl/life_engine_ctrl.sv
// Game of Life engine with run controller: computes a generation row-serially into a
// shadow buffer and commits it atomically, paced by a tick divider or single steps.
module life_engine_ctrl #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int RW       = 4,
  parameter int TICK_DIV = 268435456,
  parameter int GEN_W    = 16
) (
  input  logic                 ClkPort,
  input  logic                 reset,
  input  logic                 start_stop_i,
  input  logic                 step_i,
  input  logic                 clear_i,
  input  logic                 wrap_i,
  input  logic                 edit_we_i,
  input  logic [RW-1:0]        edit_row_i,
  input  logic [COLS-1:0]      edit_data_i,
  output logic [ROWS*COLS-1:0] board_o,
  output logic [GEN_W-1:0]     generation_cnt_o,
  output logic [1:0]           state_o,
  output logic                 busy_o,
  output logic                 extinct_o
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(ROWS);

  typedef enum logic [1:0] {
    ST_SET   = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_CALC  = 2'b11
  } state_t;

  typedef struct packed {
    logic clear;
    logic toggle;
    logic step;
    logic edit;
  } cmd_t;

  cmd_t                       cmd;
  state_t                     state, ret_state;
  logic [ROWS-1:0][COLS-1:0]  board, shadow;
  logic [GEN_W-1:0]           gen;
  logic [TW-1:0]              tick;
  logic [CW-1:0]              row_cnt;
  logic                       wrap_q;
  logic [COLS-1:0]            up_row, mid_row, dn_row, next_row;

  assign cmd = '{clear: clear_i, toggle: start_stop_i, step: step_i, edit: edit_we_i};

  // Neighbourhood rows for the row being computed; out-of-board rows read as dead unless wrapping.
  always_comb begin
    up_row  = '0;
    mid_row = '0;
    dn_row  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (CW'(r) == row_cnt) begin
        mid_row = board[r];
        if (r > 0 || wrap_q)      up_row = board[(r + ROWS - 1) % ROWS];
        if (r < ROWS - 1 || wrap_q) dn_row = board[(r + 1) % ROWS];
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int CL = (c + COLS - 1) % COLS;
    localparam int CR = (c + 1) % COLS;
    logic       lv, rv;
    logic [7:0] nb;
    logic [3:0] cnt;
    assign lv = wrap_q | (c != 0);
    assign rv = wrap_q | (c != COLS - 1);
    assign nb = {up_row[CL] & lv, up_row[c], up_row[CR] & rv,
                 mid_row[CL] & lv,           mid_row[CR] & rv,
                 dn_row[CL] & lv, dn_row[c], dn_row[CR] & rv};
    always_comb begin
      cnt = '0;
      for (int i = 0; i < 8; i++) cnt = cnt + 4'(nb[i]);
    end
    // B3/S23
    assign next_row[c] = (cnt == 4'd3) | (mid_row[c] & (cnt == 4'd2));
  end

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      state     <= ST_SET;
      ret_state <= ST_SET;
      board     <= '0;
      shadow    <= '0;
      gen       <= '0;
      tick      <= '0;
      row_cnt   <= '0;
      wrap_q    <= 1'b0;
    end else if (cmd.clear) begin
      state     <= ST_SET;
      ret_state <= ST_SET;
      board     <= '0;
      gen       <= '0;
      tick      <= '0;
      row_cnt   <= '0;
    end else begin
      case (state)
        ST_SET, ST_PAUSE: begin
          if (cmd.toggle) begin
            state <= ST_RUN;
            tick  <= '0;
          end else if (cmd.step) begin
            state     <= ST_CALC;
            ret_state <= state;
            row_cnt   <= '0;
            wrap_q    <= wrap_i;
          end else if (cmd.edit) begin
            for (int r = 0; r < ROWS; r++)
              if (RW'(r) == edit_row_i) board[r] <= edit_data_i;
          end
        end
        ST_RUN: begin
          if (cmd.toggle) begin
            state <= ST_PAUSE;
            tick  <= '0;
          end else if (tick == TICK_LAST) begin
            tick      <= '0;
            state     <= ST_CALC;
            ret_state <= ST_RUN;
            row_cnt   <= '0;
            wrap_q    <= wrap_i;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_CALC: begin
          if (row_cnt == ROW_LAST) begin
            board   <= shadow;
            gen     <= gen + 1'b1;
            state   <= ret_state;
            row_cnt <= '0;
          end else begin
            for (int r = 0; r < ROWS; r++)
              if (CW'(r) == row_cnt) shadow[r] <= next_row;
            row_cnt <= row_cnt + 1'b1;
          end
        end
        default: state <= ST_SET;
      endcase
    end
  end

  assign board_o          = board;
  assign generation_cnt_o = gen;
  assign state_o          = state;
  assign busy_o           = (state == ST_CALC);
  assign extinct_o        = ~|board;

endmodule

// File: tb/tb_life_engine_ctrl.sv
// Bench for life_engine_ctrl: command-priority table, hand sequences for the multi-cycle
// corners, and random boards checked against a plain Game of Life model.
module tb_life_engine_ctrl;
  localparam int R  = 16;
  localparam int C  = 16;
  localparam int TD = 4;
  typedef logic [R-1:0][C-1:0] brd_t;

  logic ClkPort = 1'b0;
  logic reset;
  always #5 ClkPort = ~ClkPort;

  logic           start_stop_i, step_i, clear_i, wrap_i, edit_we_i;
  logic [3:0]     edit_row_i;
  logic [C-1:0]   edit_data_i;
  logic [R*C-1:0] board_o;
  logic [15:0]    generation_cnt_o;
  logic [1:0]     state_o;
  logic           busy_o, extinct_o;

  life_engine_ctrl #(.ROWS(R), .COLS(C), .RW(4), .TICK_DIV(TD), .GEN_W(16)) u_dut (
    .ClkPort(ClkPort), .reset(reset), .start_stop_i(start_stop_i), .step_i(step_i),
    .clear_i(clear_i), .wrap_i(wrap_i), .edit_we_i(edit_we_i), .edit_row_i(edit_row_i),
    .edit_data_i(edit_data_i), .board_o(board_o), .generation_cnt_o(generation_cnt_o),
    .state_o(state_o), .busy_o(busy_o), .extinct_o(extinct_o));

  // Small non-square board with a 3-bit generation counter
  logic        b_ss, b_step, b_clear, b_wrap, b_we;
  logic [2:0]  b_row;
  logic [4:0]  b_data;
  logic [29:0] b_board;
  logic [2:0]  b_gen;
  logic [1:0]  b_state;
  logic        b_busy, b_ext;

  life_engine_ctrl #(.ROWS(6), .COLS(5), .RW(3), .TICK_DIV(2), .GEN_W(3)) u_dut_b (
    .ClkPort(ClkPort), .reset(reset), .start_stop_i(b_ss), .step_i(b_step),
    .clear_i(b_clear), .wrap_i(b_wrap), .edit_we_i(b_we), .edit_row_i(b_row),
    .edit_data_i(b_data), .board_o(b_board), .generation_cnt_o(b_gen),
    .state_o(b_state), .busy_o(b_busy), .extinct_o(b_ext));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ClkPort);
    #1;
  endtask

  task automatic pulse_ss();    start_stop_i = 1'b1; tick(); start_stop_i = 1'b0; endtask
  task automatic pulse_step();  step_i = 1'b1;       tick(); step_i = 1'b0;       endtask
  task automatic pulse_clear(); clear_i = 1'b1;      tick(); clear_i = 1'b0;      endtask

  task automatic load(input brd_t b);
    for (int r = 0; r < R; r++) begin
      edit_we_i = 1'b1; edit_row_i = 4'(r); edit_data_i = b[r];
      tick();
    end
    edit_we_i = 1'b0;
  endtask

  // Reference: count the eight neighbours of every cell directly.
  function automatic brd_t life_next(input brd_t b, input bit w);
    brd_t nx = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (w) begin
              rr = (rr + R) % R;
              cc = (cc + C) % C;
            end else if (rr < 0 || rr >= R || cc < 0 || cc >= C) continue;
            n += int'(b[rr][cc]);
          end
        nx[r][c] = (n == 3) || (b[r][c] && n == 2);
      end
    return nx;
  endfunction

  task automatic run_gens(input int n, input string nm);
    int cyc = 0;
    pulse_ss();
    while (int'(generation_cnt_o) != n && cyc < n * 40 + 100) begin
      tick();
      cyc++;
    end
    chk({nm, "_reached"}, 256'(int'(generation_cnt_o) == n), 256'(1));
    pulse_ss();
  endtask

  typedef struct {
    logic [1:0] from;
    logic [3:0] pls;      // {clear, start_stop, step, edit_we}
    logic [1:0] exp_st;
    logic       applied;
    string      nm;
  } vec_t;
  vec_t tbl[12];

  initial begin
    brd_t b0, bx, g, m, rb;
    logic [5:0][4:0] bblk;
    int exp_gen;

    tbl[0]  = '{2'd0, 4'b0001, 2'd0, 1'b1, "set_edit"};
    tbl[1]  = '{2'd0, 4'b0011, 2'd3, 1'b0, "set_step_edit"};
    tbl[2]  = '{2'd0, 4'b0110, 2'd1, 1'b0, "set_ss_step"};
    tbl[3]  = '{2'd0, 4'b1111, 2'd0, 1'b0, "set_all"};
    tbl[4]  = '{2'd0, 4'b0000, 2'd0, 1'b0, "set_idle"};
    tbl[5]  = '{2'd2, 4'b0110, 2'd1, 1'b0, "pause_ss_step"};
    tbl[6]  = '{2'd2, 4'b0010, 2'd3, 1'b0, "pause_step"};
    tbl[7]  = '{2'd2, 4'b0001, 2'd2, 1'b1, "pause_edit"};
    tbl[8]  = '{2'd1, 4'b0001, 2'd1, 1'b0, "run_edit"};
    tbl[9]  = '{2'd1, 4'b0010, 2'd1, 1'b0, "run_step"};
    tbl[10] = '{2'd1, 4'b0101, 2'd2, 1'b0, "run_ss_edit"};
    tbl[11] = '{2'd1, 4'b1000, 2'd0, 1'b0, "run_clear"};

    start_stop_i = 0; step_i = 0; clear_i = 0; wrap_i = 0; edit_we_i = 0;
    edit_row_i = 0; edit_data_i = 0;
    b_ss = 0; b_step = 0; b_clear = 0; b_wrap = 0; b_we = 0; b_row = 0; b_data = 0;
    reset = 1'b1;
    #12;
    chk("rst_board", 256'(board_o), 256'(0));
    chk("rst_gen", 256'(generation_cnt_o), 256'(0));
    chk("rst_state", 256'(state_o), 256'(0));
    chk("rst_busy", 256'(busy_o), 256'(0));
    chk("rst_extinct", 256'(extinct_o), 256'(1));
    reset = 1'b0;
    tick();

    // Blinker
    b0 = '0; b0[7][8] = 1'b1; b0[8][8] = 1'b1; b0[9][8] = 1'b1;
    bx = '0; bx[8] = 16'h0380;
    load(b0);
    chk("blk_loaded", 256'(board_o), 256'(b0));
    chk("blk_not_extinct", 256'(extinct_o), 256'(0));
    pulse_step();
    chk("blk_calc_state", 256'(state_o), 256'(3));
    chk("blk_busy", 256'(busy_o), 256'(1));
    repeat (16) tick();
    chk("blk_hold_until_commit", 256'(board_o), 256'(b0));
    chk("blk_still_calc", 256'(state_o), 256'(3));
    tick();
    chk("blk_gen1_board", 256'(board_o), 256'(bx));
    chk("blk_gen1_cnt", 256'(generation_cnt_o), 256'(1));
    chk("blk_back_set", 256'(state_o), 256'(0));
    pulse_step();
    repeat (17) tick();
    chk("blk_gen2_board", 256'(board_o), 256'(b0));
    chk("blk_gen2_cnt", 256'(generation_cnt_o), 256'(2));

    // Command priority / state gating table
    foreach (tbl[i]) begin
      pulse_clear();
      if (tbl[i].from == 2'd1) pulse_ss();
      if (tbl[i].from == 2'd2) begin pulse_ss(); pulse_ss(); end
      {clear_i, start_stop_i, step_i, edit_we_i} = tbl[i].pls;
      edit_row_i = 4'd3; edit_data_i = 16'hA5A5;
      tick();
      {clear_i, start_stop_i, step_i, edit_we_i} = 4'b0000;
      chk({tbl[i].nm, "_state"}, 256'(state_o), 256'(tbl[i].exp_st));
      chk({tbl[i].nm, "_row3"}, 256'(board_o[3*C +: C]),
          256'(tbl[i].applied ? 16'hA5A5 : 16'h0000));
    end

    // Clear during CALC cycle 5
    g = '0; g[0][1] = 1'b1; g[1][2] = 1'b1; g[2][0] = 1'b1; g[2][1] = 1'b1; g[2][2] = 1'b1;
    pulse_clear();
    load(g);
    pulse_step();
    repeat (5) tick();
    pulse_clear();
    chk("clr_calc_board", 256'(board_o), 256'(0));
    chk("clr_calc_gen", 256'(generation_cnt_o), 256'(0));
    chk("clr_calc_state", 256'(state_o), 256'(0));
    repeat (20) tick();
    chk("clr_calc_no_commit", 256'({generation_cnt_o, board_o}), 256'(0));

    // Reset mid-CALC
    load(g);
    pulse_step();
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_calc_board", 256'(board_o), 256'(0));
    chk("rst_calc_state", 256'(state_o), 256'(0));
    reset = 1'b0;
    repeat (20) tick();
    chk("rst_calc_no_commit", 256'({generation_cnt_o, board_o}), 256'(0));

    // Glider on the torus comes home after 64 generations
    wrap_i = 1'b1;
    load(g);
    run_gens(64, "glider_wrap");
    m = g;
    for (int i = 0; i < 64; i++) m = life_next(m, 1'b1);
    chk("glider_wrap_home", 256'(board_o), 256'(g));
    chk("glider_wrap_model", 256'(board_o), 256'(m));
    chk("glider_wrap_gen", 256'(generation_cnt_o), 256'(64));
    chk("glider_wrap_alive", 256'(extinct_o), 256'(0));

    // Glider with dead edges runs into the far corner
    pulse_clear();
    wrap_i = 1'b0;
    load(g);
    run_gens(60, "glider_dead");
    m = g;
    for (int i = 0; i < 60; i++) m = life_next(m, 1'b0);
    chk("glider_dead_model", 256'(board_o), 256'(m));
    chk("glider_dead_top_empty", 256'(board_o[8*C-1:0]), 256'(0));

    // Random boards, random edge mode; wrap_i flipped during CALC must not matter
    pulse_clear();
    exp_gen = 0;
    for (int i = 0; i < 12; i++) begin
      bit w;
      for (int r = 0; r < R; r++) rb[r] = C'($urandom);
      w = 1'($urandom_range(0, 1));
      wrap_i = w;
      load(rb);
      pulse_step();
      wrap_i = ~w;
      repeat (17) tick();
      exp_gen++;
      chk($sformatf("rand%0d_board", i), 256'(board_o), 256'(life_next(rb, w)));
      chk($sformatf("rand%0d_gen", i), 256'(generation_cnt_o), 256'(exp_gen));
    end

    // 3-bit generation counter wraps; a block is a still life
    b_clear = 1'b1; tick(); b_clear = 1'b0;
    bblk = '0; bblk[1] = 5'b00110; bblk[2] = 5'b00110;
    for (int r = 1; r <= 2; r++) begin
      b_we = 1'b1; b_row = 3'(r); b_data = bblk[r];
      tick();
    end
    b_we = 1'b0;
    begin
      int changes = 0;
      int cyc = 0;
      logic [2:0] prev = b_gen;
      logic ever_ext = 1'b0;
      b_ss = 1'b1; tick(); b_ss = 1'b0;
      while (changes < 9 && cyc < 600) begin
        tick();
        cyc++;
        if (b_ext) ever_ext = 1'b1;
        if (b_gen != prev) begin changes++; prev = b_gen; end
      end
      b_ss = 1'b1; tick(); b_ss = 1'b0;
      chk("genw_commits", 256'(changes), 256'(9));
      chk("genw_cnt", 256'(b_gen), 256'(1));
      chk("genw_block", 256'(b_board), 256'(bblk));
      chk("genw_never_extinct", 256'(ever_ext), 256'(0));
      chk("genw_paused", 256'(b_state), 256'(2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
